// File: rtl/hazard_control_unit.sv
// hazard_control_unit
//   Stall/flush/forward control for a five-stage pipeline, plus a small FSM
//   that freezes the pipeline while data memory is not ready and aborts the
//   M-stage access after MEM_TIMEOUT consecutive stalled cycles.
//
//   Optional feature: define HAZARD_PERF_CNT_EN to build the stall-cycle and
//   flush performance counters. Without it both counter ports read zero.
//
// Ports
//   clk, rst                 pipeline clock, asynchronous active-high reset
//   Rs1D, Rs2D               decode-stage source registers
//   Rs1E, Rs2E               execute-stage source registers
//   RdE, RdM, RdW            destination registers in E/M/W
//   RegWriteM, RegWriteW     M/W instruction writes the register file
//   ResultSrcE               2'b01 marks a load in E
//   PCSrcE                   taken branch/jump resolved in E
//   dmem_req_m, dmem_ready   M-stage memory request / completion
//   ForwardAE, ForwardBE     00 regfile, 01 ResultW, 10 ALUResultM
//   StallF/D/E/M             hold PC / IF-ID / ID-EX / EX-MEM
//   FlushD/E/M/W             bubble IF-ID / ID-EX / EX-MEM / MEM-WB
//   mem_err                  one-cycle pulse on memory timeout
//   stall_cycles             cycles with StallF=1
//   flush_count              PCSrcE flushes taken
//
// state | meaning
// RUN   | normal flow, no outstanding memory wait
// WAIT  | M-stage access not ready, pipeline frozen, wait_cnt counting
// ABORT | timeout hit: release stalls for one cycle and flush EX-MEM
module hazard_control_unit #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic             dmem_req_m,
  input  logic             dmem_ready,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             FlushW,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int             CW      = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [CW-1:0]  CNT_TOP = CW'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {RUN, WAIT, ABORT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          mem_err_q, mem_err_d;
  logic          lw_stall, mem_stall;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (RegWriteM && RdM != 5'd0 && RdM == rs)      return 2'b10;
    else if (RegWriteW && RdW != 5'd0 && RdW == rs) return 2'b01;
    else                                            return 2'b00;
  endfunction

  assign lw_stall  = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                     ((RdE == Rs1D) || (RdE == Rs2D));
  assign mem_stall = dmem_req_m && !dmem_ready && (state_q != ABORT);

  // Outputs are forced quiet while rst is high, independent of the clock.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    StallF = 1'b0; StallD = 1'b0; StallE = 1'b0; StallM = 1'b0;
    FlushD = 1'b0; FlushE = 1'b0; FlushM = 1'b0; FlushW = 1'b0;
    if (!rst) begin
      ForwardAE = fwd_sel(Rs1E);
      ForwardBE = fwd_sel(Rs2E);
      if (mem_stall) begin
        // Whole pipe frozen; a pending PCSrcE stays in ID/EX until release.
        StallF = 1'b1; StallD = 1'b1; StallE = 1'b1; StallM = 1'b1;
        FlushW = 1'b1;
      end else begin
        StallF = lw_stall;
        StallD = lw_stall;
        FlushD = PCSrcE;
        FlushE = lw_stall || PCSrcE;
        FlushM = (state_q == ABORT);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d    = WAIT;
          wait_cnt_d = CW'(1);
        end
      end
      WAIT: begin
        if (dmem_ready || !dmem_req_m) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == CNT_TOP) begin
          state_d   = ABORT;
          mem_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + CW'(1);
        end
      end
      ABORT: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  assign mem_err = mem_err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles_q, flush_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (StallF)                stall_cycles_q <= stall_cycles_q + CNT_W'(1);
      if (PCSrcE && !mem_stall)  flush_count_q  <= flush_count_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
module tb_hazard_control_unit;

  localparam int CNT_W = 32;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic             RegWriteM, RegWriteW;
  logic [1:0]       ResultSrcE;
  logic             PCSrcE, dmem_req_m, dmem_ready;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             StallF, StallD, StallE, StallM;
  logic             FlushD, FlushE, FlushM, FlushW, mem_err;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  int checks = 0;
  int errors = 0;

  hazard_control_unit #(.MEM_TIMEOUT(16), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
    .dmem_req_m(dmem_req_m), .dmem_ready(dmem_ready),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
    .mem_err(mem_err), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  // {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW, mem_err}
  function automatic logic [12:0] ctl();
    return {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
            FlushD, FlushE, FlushM, FlushW, mem_err};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegWriteM = 0; RegWriteW = 0; ResultSrcE = 2'b00;
    PCSrcE = 0; dmem_req_m = 0; dmem_ready = 0;
  endtask

  // Expected control vectors
  localparam logic [12:0] C_IDLE   = 13'b00_00_0000_0000_0;
  localparam logic [12:0] C_MEMSTL = 13'b00_00_1111_0001_0;
  localparam logic [12:0] C_LWSTL  = 13'b00_00_1100_0100_0;
  localparam logic [12:0] C_PCSRC  = 13'b00_00_0000_1100_0;
  localparam logic [12:0] C_BOTH   = 13'b00_00_1100_1100_0;
  localparam logic [12:0] C_ABORT  = 13'b00_00_0000_0010_1;

  initial begin
    clear_inputs();
    rst = 1'b1;
    // Hazard-inducing inputs while in reset must not leak through.
    RdM = 5; RegWriteM = 1; Rs1E = 5; PCSrcE = 1;
    ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
    #3;
    chk("reset_ctl", 32'(ctl()), 32'(C_IDLE));
    chk("reset_stall_cycles", stall_cycles, 0);
    chk("reset_flush_count", flush_count, 0);

    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    #1 chk("idle_ctl", 32'(ctl()), 32'(C_IDLE));

    // Forwarding
    @(negedge clk);
    RdM = 5; RegWriteM = 1; Rs1E = 5; Rs2E = 5; RdW = 5; RegWriteW = 1;
    #1 chk("fwd_m_priority_a", 32'(ForwardAE), 32'(2'b10));
    chk("fwd_m_priority_b", 32'(ForwardBE), 32'(2'b10));
    RdM = 0;
    #1 chk("fwd_rdm0_w_a", 32'(ForwardAE), 32'(2'b01));
    RegWriteW = 0;
    #1 chk("fwd_rdm0_none_a", 32'(ForwardAE), 32'(2'b00));
    RdM = 9; RegWriteM = 1; Rs1E = 9; Rs2E = 6; RdW = 6; RegWriteW = 1;
    #1 chk("fwd_mixed", 32'({ForwardAE, ForwardBE}), 32'(4'b1001));
    RegWriteM = 0;
    #1 chk("fwd_regwritem_off", 32'({ForwardAE, ForwardBE}), 32'(4'b0001));
    RdW = 0;
    #1 chk("fwd_rdw0", 32'({ForwardAE, ForwardBE}), 32'(4'b0000));
    clear_inputs();

    // Load-use
    @(negedge clk);
    ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
    #1 chk("lw_stall_rs2", 32'(ctl()), 32'(C_LWSTL));
    @(negedge clk);
    clear_inputs();
    #1 chk("lw_stall_one_cycle", 32'(ctl()), 32'(C_IDLE));
    chk("stall_cycles_after_lw", stall_cycles, PERF ? 1 : 0);
    ResultSrcE = 2'b01; RdE = 0; Rs1D = 0;
    #1 chk("lw_rde0_no_stall", 32'(ctl()), 32'(C_IDLE));
    ResultSrcE = 2'b00; RdE = 4; Rs1D = 4;
    #1 chk("non_load_no_stall", 32'(ctl()), 32'(C_IDLE));
    clear_inputs();

    // Taken branch
    @(negedge clk);
    PCSrcE = 1;
    #1 chk("pcsrc_flush", 32'(ctl()), 32'(C_PCSRC));
    @(negedge clk);
    PCSrcE = 0;
    #1 chk("flush_count_after_branch", flush_count, PERF ? 1 : 0);
    chk("branch_released", 32'(ctl()), 32'(C_IDLE));

    // Load-use and branch together
    @(negedge clk);
    PCSrcE = 1; ResultSrcE = 2'b01; RdE = 3; Rs1D = 3;
    #1 chk("lw_and_pcsrc", 32'(ctl()), 32'(C_BOTH));
    @(negedge clk);
    clear_inputs();
    #1 chk("flush_count_after_both", flush_count, PERF ? 2 : 0);
    chk("stall_cycles_after_both", stall_cycles, PERF ? 2 : 0);

    // Memory wait: not ready for 3 cycles, PCSrcE pending in first cycle
    dmem_req_m = 1; dmem_ready = 0; PCSrcE = 1;
    #1 chk("memwait_c0_pcsrc_held", 32'(ctl()), 32'(C_MEMSTL));
    @(negedge clk);
    PCSrcE = 0;
    #1 chk("memwait_c1", 32'(ctl()), 32'(C_MEMSTL));
    @(negedge clk);
    #1 chk("memwait_c2", 32'(ctl()), 32'(C_MEMSTL));
    @(negedge clk);
    dmem_ready = 1;
    #1 chk("memwait_ready_release", 32'(ctl()), 32'(C_IDLE));
    @(negedge clk);
    // Back in RUN: a request that is ready at once causes no stall.
    #1 chk("memwait_back_run", 32'(ctl()), 32'(C_IDLE));
    chk("stall_cycles_after_wait", stall_cycles, PERF ? 5 : 0);
    chk("flush_count_not_during_stall", flush_count, PERF ? 2 : 0);
    dmem_req_m = 0; dmem_ready = 0;

    // Timeout: 16 stalled cycles, then one ABORT cycle
    @(negedge clk);
    dmem_req_m = 1;
    for (int i = 0; i < 16; i++) begin
      #1 chk($sformatf("timeout_stall_%0d", i), 32'(ctl()), 32'(C_MEMSTL));
      @(negedge clk);
    end
    #1 chk("timeout_abort", 32'(ctl()), 32'(C_ABORT));
    dmem_req_m = 0;
    @(negedge clk);
    #1 chk("after_abort", 32'(ctl()), 32'(C_IDLE));
    chk("stall_cycles_after_timeout", stall_cycles, PERF ? 21 : 0);

    // Async reset in the middle of a wait
    dmem_req_m = 1; dmem_ready = 0;
    @(negedge clk); @(negedge clk);
    #1 chk("pre_reset_waiting", 32'(ctl()), 32'(C_MEMSTL));
    #2 rst = 1'b1;
    #1 chk("async_reset_ctl", 32'(ctl()), 32'(C_IDLE));
    chk("async_reset_stall_cycles", stall_cycles, 0);
    chk("async_reset_flush_count", flush_count, 0);
    @(negedge clk);
    rst = 1'b0;
    dmem_ready = 1;
    #1 chk("post_reset_ready_no_stall", 32'(ctl()), 32'(C_IDLE));
    // State restarted in RUN: the full 16-cycle budget is available again.
    dmem_ready = 0;
    for (int i = 0; i < 16; i++) begin
      #1 chk($sformatf("post_reset_stall_%0d", i), 32'(StallF), 32'(1'b1));
      @(negedge clk);
    end
    #1 chk("post_reset_abort", 32'(ctl()), 32'(C_ABORT));
    clear_inputs();
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
